alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq_cnt.sv | 37 +++
 rtl/alu_seq.sv | 139 +++++++++++++
 tb/tb_alu_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and constants for the ALU sequencer: state
//                encoding, operation-class codes and counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  // Width of the latency down-counter (covers latencies up to 63 cycles)
  localparam int CNT_W = 6;

  // Operation classes the sequencer treats specially
  localparam logic [2:0] T_MOV    = 3'd0;  // no flag update
  localparam logic [2:0] T_MULDIV = 3'd3;  // multi-cycle multiply/divide

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_seq_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : seq_cnt
//  Description : Loadable latency down-counter with zero flag. Holds at zero
//                and only counts while decrement is enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_cnt
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority over decrement; decrement stops at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule : seq_cnt
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : ALU operation sequencer. Accepts an op, holds its fields
//                stable for the op's latency, then pulses the result/flag
//                write enables or a divide-exception pulse.
//                Optional feature macro: ALU_SEQ_PERF_EN adds saturating
//                multiply/divide and exception counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int MUL_CYC = 4,   // accept-to-result latency of multiply (1..63)
  parameter int DIV_CYC = 36   // accept-to-result latency of divide   (1..63)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  t_in,
  input  logic [2:0]  func_in,
  input  logic        word_op_in,
  input  logic        abort,
  input  logic        div_exc_in,
  output logic [2:0]  t,
  output logic [2:0]  func,
  output logic        word_op,
  output logic        ready,
  output logic        hold,
  output logic        res_we,
  output logic        flags_we,
  output logic        exc
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0] muldiv_cnt,
  output logic [15:0] exc_cnt
`endif
);

  // Counter load values are latency minus one: the completion cycle is cnt=0
  localparam logic [CNT_W-1:0] c_MUL_LD = CNT_W'(MUL_CYC - 1);
  localparam logic [CNT_W-1:0] c_DIV_LD = CNT_W'(DIV_CYC - 1);

  state_t           r_state;
  logic [2:0]       r_t;
  logic [2:0]       r_func;
  logic             r_word_op;

  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_load_val;
  logic             w_run;
  logic             w_done;
  logic             w_accept;
  logic             w_is_div;
  logic             w_fire;
  logic             w_div_exc;

  assign w_run    = (r_state == RUN);
  assign w_done   = w_run && w_cnt_zero;
  assign ready    = (r_state == IDLE) || w_done;
  assign hold     = w_run;
  assign w_accept = req && ready && !abort && !rst;

  // Divide is identified from the held op fields, not the incoming request
  assign w_is_div  = (r_t == T_MULDIV) && r_func[1];
  // Completion is suppressed by abort and by reset so a dropped op stays silent
  assign w_fire    = w_done && !abort && !rst;
  assign w_div_exc = w_is_div && div_exc_in;

  assign res_we   = w_fire && !w_div_exc;
  assign flags_we = w_fire && !w_div_exc && (r_t != T_MOV);
  assign exc      = w_fire && w_div_exc;

  assign w_load_val = (t_in != T_MULDIV) ? '0 :
                      (func_in[1] ? c_DIV_LD : c_MUL_LD);

  seq_cnt u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (w_load_val),
    .i_dec      (w_run),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // Sequencer FSM and op-field registers; abort beats a same-cycle request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_t       <= 3'd0;
      r_func    <= 3'd0;
      r_word_op <= 1'b0;
    end else if (abort) begin
      r_state   <= IDLE;
    end else if (w_accept) begin
      r_state   <= RUN;
      r_t       <= t_in;
      r_func    <= func_in;
      r_word_op <= word_op_in;
    end else if (w_done) begin
      r_state   <= IDLE;
    end
  end

  assign t       = r_t;
  assign func    = r_func;
  assign word_op = r_word_op;

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] r_muldiv_cnt;
  logic [15:0] r_exc_cnt;

  // Saturating event counters for multi-cycle ops and divide exceptions
  always_ff @(posedge clk) begin
    if (rst) begin
      r_muldiv_cnt <= 16'd0;
      r_exc_cnt    <= 16'd0;
    end else begin
      if (w_accept && (t_in == T_MULDIV) && (r_muldiv_cnt != 16'hFFFF)) begin
        r_muldiv_cnt <= r_muldiv_cnt + 16'd1;
      end
      if (exc && (r_exc_cnt != 16'hFFFF)) begin
        r_exc_cnt <= r_exc_cnt + 16'd1;
      end
    end
  end

  assign muldiv_cnt = r_muldiv_cnt;
  assign exc_cnt    = r_exc_cnt;
`endif

  // Upper counter bits beyond the zero flag are not otherwise consumed
  logic w_unused;
  assign w_unused = ^w_cnt;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Scoreboard bench for alu_seq. Stimulus pushes the expected
//                completion (cycle, res_we, flags_we, exc) into a queue; a
//                monitor pops and compares on every completion-type pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [2:0] t_in;
  logic [2:0] func_in;
  logic       word_op_in;
  logic       abort;
  logic       div_exc_in;
  logic [2:0] t;
  logic [2:0] func;
  logic       word_op;
  logic       ready;
  logic       hold;
  logic       res_we;
  logic       flags_we;
  logic       exc;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] muldiv_cnt;
  logic [15:0] exc_cnt;
`endif

  alu_seq #(.MUL_CYC(4), .DIV_CYC(36)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .t_in       (t_in),
    .func_in    (func_in),
    .word_op_in (word_op_in),
    .abort      (abort),
    .div_exc_in (div_exc_in),
    .t          (t),
    .func       (func),
    .word_op    (word_op),
    .ready      (ready),
    .hold       (hold),
    .res_we     (res_we),
    .flags_we   (flags_we),
    .exc        (exc)
`ifdef ALU_SEQ_PERF_EN
    ,
    .muldiv_cnt (muldiv_cnt),
    .exc_cnt    (exc_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic r;
    logic f;
    logic e;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push(input int c, input logic r, input logic f, input logic e);
    exp_t x;
    x.cyc = c; x.r = r; x.f = f; x.e = e;
    sb.push_back(x);
  endtask

  // Monitor: every completion-type pulse must match the oldest expectation
  always @(negedge clk) begin
    if (res_we || flags_we || exc) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got res_we=%0b flags_we=%0b exc=%0b at cycle %0d, want none",
                 res_we, flags_we, exc, cyc);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (x.cyc != cyc || x.r !== res_we || x.f !== flags_we || x.e !== exc) begin
          bad++;
          $display("FAIL completion: got cyc=%0d res_we=%0b flags_we=%0b exc=%0b want cyc=%0d res_we=%0b flags_we=%0b exc=%0b",
                   cyc, res_we, flags_we, exc, x.cyc, x.r, x.f, x.e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1; req = 1'b0; t_in = 3'd0; func_in = 3'd0; word_op_in = 1'b0;
    abort = 1'b0; div_exc_in = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_hold", hold, 0);
    chk("rst_t", t, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single-cycle op: result and flags one cycle after accept
    c = cyc;
    req = 1'b1; t_in = 3'd1; func_in = 3'd0; word_op_in = 1'b1;
    push(c + 1, 1, 1, 0);
    @(negedge clk); chk("single_ready0", ready, 1);
    tick(); req = 1'b0;
    @(negedge clk);
    chk("single_ready1", ready, 1);
    chk("single_hold1", hold, 1);
    chk("single_t", t, 1);
    chk("single_word", word_op, 1);
    tick();
    @(negedge clk); chk("single_idle_hold", hold, 0);
    tick();

    // Multiply: ready low for three cycles, result on the fourth
    c = cyc;
    req = 1'b1; t_in = 3'd3; func_in = 3'd0; word_op_in = 1'b0;
    push(c + 4, 1, 1, 0);
    tick(); req = 1'b0; t_in = 3'd5;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("mul_ready_busy", ready, 0);
      chk("mul_t_held", t, 3);
      tick();
    end
    @(negedge clk);
    chk("mul_ready_done", ready, 1);
    chk("mul_t_done", t, 3);
    tick();

    // Divide: exc sampled only in the completion cycle (cycle 20 ignored)
    c = cyc;
    req = 1'b1; t_in = 3'd3; func_in = 3'd2;
    push(c + 36, 0, 0, 1);
    for (int i = 1; i <= 36; i++) begin
      tick();
      req = 1'b0;
      div_exc_in = (i == 20 || i == 36);
    end
    @(negedge clk); chk("div_ready_done", ready, 1);
    tick(); div_exc_in = 1'b0;
    tick();

    // Back-to-back: t=0 op (no flags) then a new accept in its completion cycle
    c = cyc;
    req = 1'b1; t_in = 3'd0; func_in = 3'd0;
    push(c + 1, 1, 0, 0);
    tick();
    t_in = 3'd1; func_in = 3'd3;
    push(c + 2, 1, 1, 0);
    @(negedge clk); chk("b2b_ready", ready, 1);
    tick(); req = 1'b0;
    @(negedge clk);
    chk("b2b_t", t, 1);
    chk("b2b_func", func, 3);
    tick();
    tick();

    // Abort with a simultaneous request mid-divide: no result, no accept
    req = 1'b1; t_in = 3'd3; func_in = 3'd2;
    tick(); req = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    abort = 1'b1; req = 1'b1; t_in = 3'd1; func_in = 3'd1;
    tick();
    abort = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("abort_hold", hold, 0);
    chk("abort_ready", ready, 1);
    chk("abort_t", t, 3);
    chk("abort_func", func, 2);
    for (int i = 0; i < 40; i++) tick();

    // Reset in the middle of a multiply drops it silently
    req = 1'b1; t_in = 3'd3; func_in = 3'd0; word_op_in = 1'b1;
    tick(); req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_hold", hold, 0);
    chk("mrst_ready", ready, 1);
    chk("mrst_t", t, 0);
    chk("mrst_func", func, 0);
    chk("mrst_word", word_op, 0);
`ifdef ALU_SEQ_PERF_EN
    chk("mrst_muldiv_cnt", muldiv_cnt, 0);
`endif
    for (int i = 0; i < 8; i++) tick();

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_seq
`default_nettype wire
